// File: rtl/uart_rx_deserializer_pkg.sv
// Shared types and constants for the UART receive deserializer.
// Holds the RX FIFO slot bit positions, FSM state encoding and latched format.
// Helper functions derive bit count and expected parity from the format.
package uart_rx_deserializer_pkg;

  // Error flag positions inside the 11-bit RX FIFO slot.
  localparam int RX_BI = 10;
  localparam int RX_FE = 9;
  localparam int RX_PE = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_t;

  typedef struct packed {
    logic [1:0] word_len;
    logic       parity_en;
    logic       even_parity;
    logic       stick_parity;
  } rx_fmt_t;

  // Index of the last data bit: 5 bits -> 4, ..., 8 bits -> 7.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] word_len);
    return {1'b0, word_len} + 3'd4;
  endfunction

  // Parity bit the transmitter should have sent. Unused data bits are zero,
  // so a full 8-bit reduction is correct for every word length.
  function automatic logic expected_parity(input rx_fmt_t fmt, input logic [7:0] data);
    if (fmt.stick_parity) return ~fmt.even_parity;
    if (fmt.even_parity)  return ^data;
    return ~(^data);
  endfunction

endpackage

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronises rxd, detects start on the 16x tick,
// deserialises 5-8 data bits with optional parity and checks the first stop bit.
// Writes one 11-bit entry plus error flag per character, never backpressured.
module uart_rx_deserializer
  import uart_rx_deserializer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        baud_x16,
  input  logic        rxd,
  input  logic [1:0]  word_len,
  input  logic        parity_en,
  input  logic        even_parity,
  input  logic        stick_parity,
  output logic [10:0] rx_word,
  output logic        rx_err,
  output logic        rx_we,
  output logic        rx_busy
);

  rx_state_t   state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [3:0]  tcnt_q, tcnt_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  data_q, data_d;
  logic        par_q, par_d;
  rx_fmt_t     fmt_q, fmt_d;
  logic [10:0] rx_word_q, rx_word_d;
  logic        rx_err_q, rx_err_d;
  logic        rx_we_q, rx_we_d;

  logic rxs;
  logic mid_bit;
  logic last_data;
  logic brk;
  logic pe;
  logic fe;

  assign rxs       = sync_q[1];
  assign mid_bit   = (tcnt_q == 4'd15);
  assign last_data = (bcnt_q == last_bit_idx(fmt_q.word_len));

  // Stop-bit evaluation; only consumed on the stop sample tick.
  assign fe  = ~rxs;
  assign brk = (data_q == 8'h00) && (!fmt_q.parity_en || !par_q) && !rxs;
  assign pe  = fmt_q.parity_en && (par_q != expected_parity(fmt_q, data_q));

  // State register plus all datapath flops; synchroniser idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sync_q    <= 2'b11;
      tcnt_q    <= 4'd0;
      bcnt_q    <= 3'd0;
      data_q    <= 8'h00;
      par_q     <= 1'b0;
      fmt_q     <= '0;
      rx_word_q <= 11'h000;
      rx_err_q  <= 1'b0;
      rx_we_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      data_q    <= data_d;
      par_q     <= par_d;
      fmt_q     <= fmt_d;
      rx_word_q <= rx_word_d;
      rx_err_q  <= rx_err_d;
      rx_we_q   <= rx_we_d;
    end
  end

  // Next-state logic; every transition is qualified by the 16x tick.
  always_comb begin
    state_d = state_q;
    if (baud_x16) begin
      case (state_q)
        ST_IDLE:     if (!rxs) state_d = ST_START;
        ST_START:    if (tcnt_q == 4'd7) state_d = rxs ? ST_IDLE : ST_DATA;
        ST_DATA:     if (mid_bit && last_data)
                       state_d = fmt_q.parity_en ? ST_PARITY : ST_STOP;
        ST_PARITY:   if (mid_bit) state_d = ST_STOP;
        ST_STOP:     if (mid_bit) state_d = rxs ? ST_IDLE : ST_BRK_WAIT;
        ST_BRK_WAIT: if (rxs) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Counters, shift register, format latch and the registered FIFO write.
  always_comb begin
    sync_d    = {sync_q[0], rxd};
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    data_d    = data_q;
    par_d     = par_q;
    fmt_d     = fmt_q;
    rx_word_d = rx_word_q;
    rx_err_d  = rx_err_q;
    rx_we_d   = 1'b0;
    if (baud_x16) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            tcnt_d = 4'd0;
            bcnt_d = 3'd0;
            data_d = 8'h00;
            par_d  = 1'b0;
            fmt_d  = '{word_len: word_len, parity_en: parity_en,
                       even_parity: even_parity, stick_parity: stick_parity};
          end
        end
        ST_START: begin
          tcnt_d = (tcnt_q == 4'd7) ? 4'd0 : tcnt_q + 4'd1;
          bcnt_d = 3'd0;
        end
        ST_DATA: begin
          // tcnt wraps 15 -> 0 on the sample, aligning the next bit centre.
          tcnt_d = tcnt_q + 4'd1;
          if (mid_bit) begin
            data_d[bcnt_q] = rxs;
            bcnt_d         = bcnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          tcnt_d = tcnt_q + 4'd1;
          if (mid_bit) par_d = rxs;
        end
        ST_STOP: begin
          tcnt_d = tcnt_q + 4'd1;
          if (mid_bit) begin
            rx_word_d         = {3'b000, data_q};
            rx_word_d[RX_PE]  = pe;
            rx_word_d[RX_FE]  = fe;
            if (brk) begin
              rx_word_d        = 11'h000;
              rx_word_d[RX_BI] = 1'b1;
              rx_word_d[RX_FE] = 1'b1;
            end
            rx_err_d = |rx_word_d[10:8];
            rx_we_d  = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs: busy decodes the state, the FIFO interface comes straight from flops.
  always_comb begin
    rx_busy = (state_q != ST_IDLE);
    rx_word = rx_word_q;
    rx_err  = rx_err_q;
    rx_we   = rx_we_q;
  end

endmodule
